// File: rtl/timer_pkg.sv
// Shared definitions for the peripheral-cluster timers: edge selection
// encoding, default widths and the edge qualification rule.
package timer_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_sel_e;

  localparam int TIMER_CNT_W       = 16;
  localparam int TIMER_PSC_W       = 5;
  localparam int TIMER_SYNC_STAGES = 2;

  function automatic logic edge_hit(edge_sel_e sel, logic cur, logic prev);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: one tick every psc+1 enabled cycles, with a
// synchronous clear that restarts the count phase.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = TIMER_PSC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             clr,
  output logic             tick
);

  logic [PSC_W-1:0] presc;

  // Compare uses the live psc; a count already above a lowered psc runs on
  // and wraps naturally at the top of the register.
  assign tick = en && (presc == psc);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (tick) presc <= '0;
      else      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/timer_capture.sv
// Input-capture timer: measures prescaled ticks between qualifying edges of
// an asynchronous input and holds each result in a valid/ack register.
module timer_capture
  import timer_pkg::*;
#(
  parameter int CNT_W       = TIMER_CNT_W,
  parameter int PSC_W       = TIMER_PSC_W,
  parameter int SYNC_STAGES = TIMER_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic [1:0]       edge_sel,
  input  logic             cap_in,
  input  logic             cap_ack,
  output logic [CNT_W-1:0] cap_val,
  output logic             cap_sat,
  output logic             cap_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] cnt
);

  // Capture handshake: cap_valid rises when a measurement is loaded and
  // stays up, with cap_val/cap_sat frozen, until a cycle with cap_ack=1.
  // An ack in the same cycle as a new event frees the slot for that event.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   prev;
  logic                   event_hit;
  logic                   tick;
  logic                   sat;
  logic                   armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], cap_in};
      prev <= sync_out;
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];

  // prev tracks even while disabled so re-enabling never sees a stale edge.
  assign event_hit = en && edge_hit(edge_sel_e'(edge_sel), sync_out, prev);

  tick_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .psc  (psc),
    .clr  (event_hit),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (event_hit) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (tick) begin
      if (cnt == CNT_MAX) sat <= 1'b1;
      else                cnt <= cnt + 1'b1;
    end
  end

  // The first event after reset only starts a measurement window.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      cap_val   <= '0;
      cap_sat   <= 1'b0;
      cap_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (event_hit) begin
      if (!armed) begin
        armed <= 1'b1;
      end else if (!cap_valid || cap_ack) begin
        cap_val   <= cnt;
        cap_sat   <= sat;
        cap_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (cap_ack && cap_valid) begin
      cap_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_capture.sv
// Bench for timer_capture: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against an interval model.
module tb_timer_capture;

  localparam int PSC_W = 5;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             reset, en, cap_in, cap_ack;
  logic [PSC_W-1:0] psc;
  logic [1:0]       edge_sel;

  logic [15:0] cap_val, cnt;
  logic        cap_sat, cap_valid, overrun;
  logic [3:0]  cap_val4, cnt4;
  logic        cap_sat4, cap_valid4, overrun4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  always #5 clk = ~clk;

  timer_capture dut (
    .clk(clk), .reset(reset), .en(en), .psc(psc), .edge_sel(edge_sel),
    .cap_in(cap_in), .cap_ack(cap_ack), .cap_val(cap_val), .cap_sat(cap_sat),
    .cap_valid(cap_valid), .overrun(overrun), .cnt(cnt)
  );

  timer_capture #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .psc(psc), .edge_sel(edge_sel),
    .cap_in(cap_in), .cap_ack(cap_ack), .cap_val(cap_val4), .cap_sat(cap_sat4),
    .cap_valid(cap_valid4), .overrun(overrun4), .cnt(cnt4)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a measurement is the number of whole prescaler periods
  // in the enabled, non-event cycles strictly between two event cycles.
  logic hist[$];
  int   m_e, m_t, m_cnt_t, t;
  bit   m_armed, m_valid, m_ovr, ev;

  function automatic bit hit(logic [1:0] sel, logic cur, logic prv);
    case (sel)
      2'b00:   return cur && !prv;
      2'b01:   return !cur && prv;
      2'b10:   return cur != prv;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int clampv(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_e = 0; m_t = 0; m_cnt_t = 0;
      m_armed = 0; m_valid = 0; m_ovr = 0;
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    end else begin
      ev = en && hit(edge_sel, hist[S-1], hist[S]);
      t  = m_e / (int'(psc) + 1);
      if (ev) begin
        if (!m_armed)                    m_armed = 1;
        else if (!m_valid || cap_ack) begin m_t = t; m_valid = 1; end
        else                             m_ovr = 1;
      end else if (cap_ack && m_valid) begin
        m_valid = 0; m_ovr = 0;
      end
      if (ev)      m_e = 0;
      else if (en) m_e++;
      m_cnt_t = m_e / (int'(psc) + 1);
      hist.push_front(cap_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_valid", 32'(cap_valid), 32'(m_valid));
      check("m_val", 32'(cap_val), 32'(clampv(m_t, 16)));
      check("m_sat", 32'(cap_sat), 32'(m_t > 65535));
      check("m_ovr", 32'(overrun), 32'(m_ovr));
      check("m_cnt", 32'(cnt), 32'(clampv(m_cnt_t, 16)));
      check("m_valid4", 32'(cap_valid4), 32'(m_valid));
      check("m_val4", 32'(cap_val4), 32'(clampv(m_t, 4)));
      check("m_sat4", 32'(cap_sat4), 32'(m_t > 15));
      check("m_ovr4", 32'(overrun4), 32'(m_ovr));
      check("m_cnt4", 32'(cnt4), 32'(clampv(m_cnt_t, 4)));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic rise_pulse(int gap);
    cap_in = 1'b1;
    steps(gap / 2);
    cap_in = 1'b0;
    steps(gap - gap / 2);
  endtask

  typedef struct {
    int         psc;
    logic [1:0] sel;
    int         gap;
    int         exp16;
    int         exp4;
    bit         sat4;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(vec_t v);
    logic base;
    base     = (v.sel == 2'b01);
    psc      = v.psc[PSC_W-1:0];
    edge_sel = v.sel;
    cap_in   = base;
    do_reset();
    steps(4);
    cap_in = ~cap_in;
    for (int i = 1; i < v.gap; i++) begin
      step();
      if (i == v.gap / 2 && v.sel != 2'b10) cap_in = base;
      if (i == 3) check("arm_only", 32'(cap_valid), 32'd0);
    end
    step();
    cap_in = (v.sel == 2'b10) ? ~cap_in : ~base;
    steps(2);
    check("latency_early", 32'(cap_valid), 32'd0);
    step();
    check("vec_valid", 32'(cap_valid), 32'd1);
    check("vec_val", 32'(cap_val), 32'(v.exp16));
    check("vec_sat", 32'(cap_sat), 32'd0);
    check("vec_val4", 32'(cap_val4), 32'(v.exp4));
    check("vec_sat4", 32'(cap_sat4), 32'(v.sat4));
    cap_ack = 1'b1;
    step();
    cap_ack = 1'b0;
    check("vec_ack", 32'(cap_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; cap_in = 1'b0; cap_ack = 1'b0;
    psc = '0; edge_sel = 2'b00;
    // Expected capture = floor((gap-1)/(psc+1)); gap = cycles between edges.
    vecs[0] = '{3,  2'b00, 40,  9,  9, 1'b0};
    vecs[1] = '{0,  2'b10, 5,   4,  4, 1'b0};
    vecs[2] = '{0,  2'b10, 7,   6,  6, 1'b0};
    vecs[3] = '{0,  2'b00, 30,  29, 15, 1'b1};
    vecs[4] = '{0,  2'b00, 16,  15, 15, 1'b0};
    vecs[5] = '{0,  2'b00, 17,  16, 15, 1'b1};
    vecs[6] = '{31, 2'b01, 100, 3,  3, 1'b0};
    vecs[7] = '{1,  2'b01, 9,   4,  4, 1'b0};
    vecs[8] = '{2,  2'b00, 6,   1,  1, 1'b0};

    @(negedge clk);
    step();
    reset = 1'b0;
    check("rst_valid", 32'(cap_valid), 32'd0);
    check("rst_val", 32'(cap_val), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    chk_on = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // No ack across three events: first capture held, overrun sticky.
    psc = '0; edge_sel = 2'b00; cap_in = 1'b0;
    do_reset();
    steps(3);
    rise_pulse(8); rise_pulse(10); rise_pulse(12); rise_pulse(6);
    steps(3);
    check("ovr_val", 32'(cap_val), 32'd7);
    check("ovr_valid", 32'(cap_valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    cap_ack = 1'b1; step(); cap_ack = 1'b0;
    check("ack_valid", 32'(cap_valid), 32'd0);
    check("ack_ovr", 32'(overrun), 32'd0);

    // Ack landing in the same cycle as the next event.
    cap_in = 1'b1; steps(5); cap_in = 1'b0; steps(5);
    cap_in = 1'b1; steps(2);
    cap_ack = 1'b1; step(); cap_ack = 1'b0;
    check("coinc_valid", 32'(cap_valid), 32'd1);
    check("coinc_val", 32'(cap_val), 32'd9);
    check("coinc_ovr", 32'(overrun), 32'd0);
    cap_in = 1'b0; steps(3);
    cap_ack = 1'b1; step(); cap_ack = 1'b0;

    // Disabled window: 20 frozen cycles, an edge inside it is ignored.
    do_reset();
    steps(3);
    cap_in = 1'b1; steps(3); cap_in = 1'b0; steps(5);
    en = 1'b0; steps(5); cap_in = 1'b1; steps(5); cap_in = 1'b0; steps(10);
    en = 1'b1; steps(7);
    check("no_spurious", 32'(cap_valid), 32'd0);
    steps(3);
    cap_in = 1'b1; steps(3);
    check("frz_valid", 32'(cap_valid), 32'd1);
    check("frz_val", 32'(cap_val), 32'd17);
    check("frz_val4", 32'(cap_val4), 32'd15);
    check("frz_sat4", 32'(cap_sat4), 32'd1);

    // One-cycle reset while a capture is pending.
    steps(4);
    cap_in = 1'b0;
    do_reset();
    check("mid_rst_valid", 32'(cap_valid), 32'd0);
    check("mid_rst_val", 32'(cap_val), 32'd0);
    check("mid_rst_sat4", 32'(cap_sat4), 32'd0);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    steps(2);
    rise_pulse(12);
    check("post_rst_arm", 32'(cap_valid), 32'd0);
    cap_in = 1'b1; steps(3);
    check("post_rst_val", 32'(cap_val), 32'd11);

    // Capture disabled: no events, counter keeps running.
    psc = 5'd4; edge_sel = 2'b11; cap_in = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cap_in = ~cap_in;
      steps(4);
    end
    check("off_cnt", 32'(cnt), 32'd4);
    check("off_valid", 32'(cap_valid), 32'd0);

    // Random traffic, prescaler and edge mode fixed per segment.
    for (int seg = 0; seg < 8; seg++) begin
      psc = PSC_W'($urandom_range(0, 3));
      edge_sel = 2'($urandom_range(0, 3));
      cap_ack = 1'b0;
      do_reset();
      repeat (400) begin
        en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 5) == 0) cap_in = ~cap_in;
        cap_ack = ($urandom_range(0, 3) == 0);
        step();
      end
    end

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
